uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
- Single-clock serial transmit core with three parts: a free-running baud-rate tick generator, an 8N1 UART transmitter with a start/busy handshake, and a free-running periodic timer tick.
- Sits between byte-sequencing logic (string/packet senders) and the FPGA serial output pin.
- The timer tick paces periodic retransmission in the parent.
- All timing is derived from the 24 MHz system clock via clock enables; the block creates no derived clocks.

Parameters:
- BAUD_DIV, 2500, system clocks per bit period (24 MHz / 9600 baud); legal range >= 2.
- TIMER_DIV, 2400000, system clocks per timer tick period (100 ms at 24 MHz); legal range >= 2.

Ports:
- clk_24MHz  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  8  byte to transmit; sampled only at frame acceptance.
- start  input  1  transmit request level; hold high until busy is seen high, then drop.
- line  output  1  serial TX line; idle high.
- busy  output  1  high while a frame is in progress.
- baud_tick  output  1  one-cycle pulse once per bit period.
- timer_tick  output  1  one-cycle pulse once per TIMER_DIV clocks.

Behaviour:
- Reset (rst_n low) takes effect immediately, without waiting for a clock edge:
  - line=1, busy=0, baud_tick=0, timer_tick=0.
  - All counters, the shift register and the bit index clear to 0.
  - Reset in the middle of a frame aborts it; line returns high at once.
  - After reset is released, no frame starts until a new acceptance occurs.
- Baud generator:
  - Counter runs 0..BAUD_DIV-1 continuously from reset release, independent of transmitter state.
  - baud_tick=1 for exactly the one cycle in which the counter equals BAUD_DIV-1; the counter then wraps to 0.
  - First tick comes BAUD_DIV cycles after reset release; period is exactly BAUD_DIV.
- Timer: same structure as the baud generator using TIMER_DIV, driving timer_tick. It is unaffected by UART activity.
- Transmitter states are IDLE, START, DATA, STOP. Every transition happens only in a cycle where baud_tick=1.
  - IDLE: line=1, busy=0. On a tick with start=1:
    - latch data into the shift register;
    - go to START;
    - line=0 and busy=1 from the next cycle.
  - START: on the next tick go to DATA with bit index 0; line=data[0].
  - DATA: each tick advances the bit index. Bits go out LSB first; line shows data[i] for bit i.
    - After bit 7's period ends (tick with index 7), go to STOP; line=1.
  - STOP: on the next tick go to IDLE; busy=0 from the next cycle.
- Frame timing:
  - A frame is 10 bit periods: 1 start, 8 data, 1 stop.
  - busy is high for exactly 10*BAUD_DIV cycles.
  - line and busy are registered and change together in the cycle after the tick.
- Acceptance latency: from start rising to line falling is 1..BAUD_DIV cycles, because acceptance waits for the next tick.
- Changes on data or start during a frame are ignored; the transmitted byte is the one latched at acceptance.
- Back-to-back frames:
  - The tick that ends STOP returns to IDLE without sampling start.
  - If start is still high, the next frame is accepted at the following tick.
  - This guarantees at least one idle-high bit period (stop plus one idle bit) between frames.
  - Requesters that follow the rule "drop start once busy is high" get exactly one frame per request.
- start may arrive in the same cycle as a baud tick; it is accepted at that tick.
- All outputs are glitch-free registered signals.

Test Plan:
1. Reset, then release; count clocks. Required:
   - first baud_tick at cycle 2500, then every 2500 cycles;
   - first timer_tick at cycle 2400000;
   - line=1 and busy=0 throughout.
2. data=0x41, raise start; drop start once busy=1. Required:
   - line sequence per bit period: 0, 1,0,0,0,0,0,1,0, 1;
   - busy high for exactly 25000 cycles;
   - line returns to idle 1.
3. Send 0x41, 0x42, 0x43, 0x44 back-to-back; raise start for the next byte as soon as busy falls. Required:
   - four correct 8N1 frames;
   - at least one idle bit period between them;
   - no byte sent twice.
4. Hold start high continuously with data=0xFF. Required:
   - repeated frames, each separated by exactly one idle bit period after the stop bit.
5. Change data from 0x55 to 0xAA two bit periods into a 0x55 frame. Required: the transmitted byte remains 0x55.
6. Assert rst_n low during data bit 3. Required:
   - line=1 and busy=0 immediately;
   - after release, line stays high until a new start is accepted.

Source files
------------

// File: rtl/uart_tx_core_if.sv
// Byte handshake between a sequencer and the UART transmitter.
// The master drives data/start; the transmitter returns the serial line and busy.
interface uart_tx_core_if;
  logic [7:0] data;
  logic       start;
  logic       line;
  logic       busy;

  modport master (
    output data,
    output start,
    input  line,
    input  busy
  );

  modport slave (
    input  data,
    input  start,
    output line,
    output busy
  );
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with a free-running baud tick and a periodic timer tick.
// Every piece of timing is a clock enable derived from clk_24MHz.
module uart_tx_core #(
  parameter int unsigned BAUD_DIV  = 2500,
  parameter int unsigned TIMER_DIV = 2400000
) (
  input  logic          clk_24MHz,
  input  logic          rst_n,
  uart_tx_core_if.slave tx,
  output logic          baud_tick,
  output logic          timer_tick
);

  localparam int unsigned BaudW  = $clog2(BAUD_DIV);
  localparam int unsigned TimerW = $clog2(TIMER_DIV);
  localparam logic [BaudW-1:0]  BaudMax  = BaudW'(BAUD_DIV - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMER_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [BaudW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [TimerW-1:0] timer_cnt_q, timer_cnt_d;
  logic              baud_tick_q, timer_tick_q;

  state_e            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              line_q, line_d;
  logic              busy_q, busy_d;

  always_comb begin
    baud_cnt_d  = (baud_cnt_q == BaudMax) ? '0 : baud_cnt_q + 1'b1;
    timer_cnt_d = (timer_cnt_q == TimerMax) ? '0 : timer_cnt_q + 1'b1;
  end

  // Ticks are registered so they are high exactly while the counter sits at its max.
  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_q   <= '0;
      timer_cnt_q  <= '0;
      baud_tick_q  <= 1'b0;
      timer_tick_q <= 1'b0;
    end else begin
      baud_cnt_q   <= baud_cnt_d;
      timer_cnt_q  <= timer_cnt_d;
      baud_tick_q  <= (baud_cnt_d == BaudMax);
      timer_tick_q <= (timer_cnt_d == TimerMax);
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    line_d    = line_q;
    busy_d    = busy_q;
    if (baud_tick_q) begin
      case (state_q)
        StIdle: begin
          if (tx.start) begin
            shift_d = tx.data;
            state_d = StStart;
            line_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        StStart: begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          line_d    = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end
        StData: begin
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            line_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            line_d    = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
        StStop: begin
          // start is not sampled here, which guarantees one idle bit between frames.
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
    end
  end

  assign tx.line    = line_q;
  assign tx.busy    = busy_q;
  assign baud_tick  = baud_tick_q;
  assign timer_tick = timer_tick_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed and randomized checks of uart_tx_core against a frame-level reference.
module tb_uart_tx_core;
  localparam int BD = 16;
  localparam int TD = 200;

  logic clk_24MHz = 1'b0;
  logic rst_n     = 1'b1;
  logic baud_tick;
  logic timer_tick;

  uart_tx_core_if bus();

  uart_tx_core #(
    .BAUD_DIV (BD),
    .TIMER_DIV(TD)
  ) dut (
    .clk_24MHz (clk_24MHz),
    .rst_n     (rst_n),
    .tx        (bus),
    .baud_tick (baud_tick),
    .timer_tick(timer_tick)
  );

  always #5 clk_24MHz = ~clk_24MHz;

  int n_tests  = 0;
  int n_fail   = 0;
  int tick_err = 0;
  int n_baud   = 0;
  int n_timer  = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; ticks are expected on cycles BD, 2*BD, ... counted from reset release.
  task automatic do_cycle();
    logic exp_b, exp_t;
    @(posedge clk_24MHz);
    if (rst_n) cyc++;
    @(negedge clk_24MHz);
    exp_b = rst_n && ((cyc % BD) == BD - 1);
    exp_t = rst_n && ((cyc % TD) == TD - 1);
    if (baud_tick !== exp_b || timer_tick !== exp_t) tick_err++;
    if (baud_tick === 1'b1) n_baud++;
    if (timer_tick === 1'b1) n_timer++;
  endtask

  task automatic idle_run(input string tag, input int n);
    int err = 0;
    repeat (n) begin
      do_cycle();
      if (bus.line !== 1'b1 || bus.busy !== 1'b0) err++;
    end
    check(tag, 32'(err), 32'd0);
  endtask

  // Waits for a frame, samples each bit mid-period and checks busy length.
  task automatic frame(input string tag, input logic [7:0] exp, input bit drop,
                       input int chg_at, input logic [7:0] chg_data, output int waited);
    logic [9:0] rx = '0;
    int len = 0;
    waited = 0;
    while (bus.line !== 1'b0 && waited <= 3 * BD) begin
      do_cycle();
      waited++;
    end
    check({tag, "_fall"}, 32'(bus.line), 32'd0);
    if (bus.line !== 1'b0) return;
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    while (bus.busy === 1'b1 && len < 12 * BD) begin
      if ((len % BD) == BD / 2 && (len / BD) < 10) rx[len / BD] = bus.line;
      if (drop) bus.start = 1'b0;
      if (len == chg_at) bus.data = chg_data;
      do_cycle();
      len++;
    end
    check({tag, "_busy_len"}, 32'(len), 32'(10 * BD));
    check({tag, "_bits"}, 32'(rx), 32'({1'b1, exp, 1'b0}));
    check({tag, "_idle"}, 32'(bus.line), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] r;
    bus.data  = 8'h00;
    bus.start = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_line", 32'(bus.line), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_baud", 32'(baud_tick), 32'd0);
    check("rst_timer", 32'(timer_tick), 32'd0);
    @(negedge clk_24MHz);
    do_cycle();
    do_cycle();
    rst_n = 1'b1;
    cyc   = 0;

    // 1: free-running ticks and idle line
    idle_run("t1_idle", 2 * TD + 5);
    check("t1_baud_count", 32'(n_baud), 32'((2 * TD + 6) / BD));
    check("t1_timer_count", 32'(n_timer), 32'd2);
    check("t1_tick_timing", 32'(tick_err), 32'd0);

    // 2: single 0x41 frame from a random phase
    repeat ($urandom_range(0, BD - 1)) do_cycle();
    bus.data  = 8'h41;
    bus.start = 1'b1;
    frame("t2", 8'h41, 1'b1, -1, 8'h00, w);
    check("t2_latency", 32'(w >= 1 && w <= BD), 32'd1);

    // 3: back-to-back, next start raised as busy falls
    for (int j = 0; j < 4; j++) begin
      bus.data  = 8'h41 + 8'(j);
      bus.start = 1'b1;
      frame($sformatf("t3_%0d", j), 8'h41 + 8'(j), 1'b1, -1, 8'h00, w);
      if (j > 0) check($sformatf("t3_gap_%0d", j), 32'(w >= BD), 32'd1);
    end
    idle_run("t3_no_repeat", 3 * BD);

    // 4: start held high continuously
    bus.data  = 8'hFF;
    bus.start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      frame($sformatf("t4_%0d", j), 8'hFF, 1'b0, -1, 8'h00, w);
      if (j > 0) check($sformatf("t4_gap_%0d", j), 32'(w), 32'(BD));
    end
    bus.start = 1'b0;
    idle_run("t4_stop", 2 * BD);

    // 5: data changes mid-frame
    bus.data  = 8'h55;
    bus.start = 1'b1;
    frame("t5", 8'h55, 1'b1, 2 * BD, 8'hAA, w);

    // 6: reset during data bit 3
    r         = 8'($urandom);
    bus.data  = r;
    bus.start = 1'b1;
    w         = 0;
    while (bus.line !== 1'b0 && w <= 3 * BD) begin
      do_cycle();
      w++;
    end
    check("t6_fall", 32'(bus.line), 32'd0);
    bus.start = 1'b0;
    repeat (4 * BD + BD / 2) do_cycle();
    check("t6_bit3", 32'(bus.line), 32'(r[3]));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_line", 32'(bus.line), 32'd1);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_ticks", 32'({baud_tick, timer_tick}), 32'd0);
    do_cycle();
    do_cycle();
    rst_n = 1'b1;
    cyc   = 0;
    idle_run("t6_post_idle", 3 * BD);
    bus.data  = ~r;
    bus.start = 1'b1;
    frame("t6_recover", ~r, 1'b1, -1, 8'h00, w);

    // 7: random bytes with random gaps
    for (int j = 0; j < 6; j++) begin
      repeat ($urandom_range(0, 2 * BD)) do_cycle();
      r         = 8'($urandom);
      bus.data  = r;
      bus.start = 1'b1;
      frame($sformatf("t7_%0d", j), r, 1'b1, -1, 8'h00, w);
      check($sformatf("t7_lat_%0d", j), 32'(w >= 1 && w <= BD), 32'd1);
    end

    check("tick_timing_all", 32'(tick_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
